// File: rtl/banked_ram_array.sv
// -----------------------------------------------------------------------------
// banked_ram_array
//
// Banked scratch RAM for the convolution datapath. It has one write port and
// one read port per cycle, byte-enable writes, and a registered read with a
// latency of 1 or 2 cycles plus a valid strobe. The read-during-write policy is
// selectable. A clear sequencer zeroes every bank in parallel, one row per
// cycle.
//
// Address split: bank = addr mod NUM_BANKS (low bits), row = addr / NUM_BANKS.
//
// Ports
//   i_clk          clock
//   i_rst          synchronous, active-high reset
//   i_clear        pulse; starts a clear sequence when idle
//   o_busy         high while clearing; write/read requests are ignored
//   i_we           write enable
//   i_write_addr   write word address
//   i_wstrb        byte enables, bit k covers data[8k+7:8k]
//   i_data         write data
//   i_re           read request
//   i_read_addr    read word address
//   o_data         read data, zero when o_valid is low
//   o_valid        o_data valid this cycle
//
// FSM states
//   state    | meaning
//   ST_IDLE  | normal operation, ports accepted
//   ST_CLEAR | zeroing row r_clr_cnt of every bank, ports ignored
// -----------------------------------------------------------------------------
module banked_ram_array #(
    parameter int VALID_ADDR_WIDTH = 14,
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_BANKS        = 4,
    parameter int READ_LATENCY     = 1,
    parameter int WRITE_FIRST      = 1,
    parameter int CLEAR_ON_RESET   = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_clear,
    output logic                        o_busy,
    input  logic                        i_we,
    input  logic [VALID_ADDR_WIDTH-1:0] i_write_addr,
    input  logic [DATA_WIDTH/8-1:0]     i_wstrb,
    input  logic [DATA_WIDTH-1:0]       i_data,
    input  logic                        i_re,
    input  logic [VALID_ADDR_WIDTH-1:0] i_read_addr,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic                        o_valid
);

    localparam int DEPTH     = 2 ** VALID_ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int BANK_W    = $clog2(NUM_BANKS);
    localparam int BANK_IW   = (BANK_W > 0) ? BANK_W : 1;
    localparam int ROWS      = DEPTH / NUM_BANKS;
    localparam int ROW_W     = VALID_ADDR_WIDTH - BANK_W;
    localparam int ROW_IW    = (ROW_W > 0) ? ROW_W : 1;

    // Elaboration-time parameter sanity checks
    if ((DATA_WIDTH % 8) != 0) begin : g_chk_dw
        $error("banked_ram_array: DATA_WIDTH must be a multiple of 8");
    end
    if ((2 ** BANK_W) != NUM_BANKS || NUM_BANKS > DEPTH) begin : g_chk_nb
        $error("banked_ram_array: NUM_BANKS must be a power of two <= DEPTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_chk_rl
        $error("banked_ram_array: READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    logic [ROW_IW-1:0]   r_clr_cnt;
    logic                r_busy;

    logic                w_idle;
    logic                w_clr_en;
    logic                w_wr_en;
    logic                w_rd_en;
    logic [BANK_IW-1:0]  w_wr_bank;
    logic [ROW_IW-1:0]   w_wr_row;
    logic [BANK_IW-1:0]  w_rd_bank;
    logic [ROW_IW-1:0]   w_rd_row;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clr_cnt <= '0;
            if (CLEAR_ON_RESET != 0) begin
                r_state <= ST_CLEAR;
                r_busy  <= 1'b1;
            end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clear) begin
                        r_state   <= ST_CLEAR;
                        r_busy    <= 1'b1;
                        r_clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == ROW_IW'(ROWS - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + ROW_IW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;

    // A reset edge touches no memory word, including a clear row in flight.
    assign w_idle   = (r_state == ST_IDLE) && !i_rst;
    assign w_clr_en = (r_state == ST_CLEAR) && !i_rst;
    assign w_wr_en  = w_idle && i_we;
    assign w_rd_en  = w_idle && i_re;

    // NUM_BANKS is a power of two, so these reduce to bit slices.
    assign w_wr_bank = BANK_IW'(i_write_addr % NUM_BANKS);
    assign w_wr_row  = ROW_IW'(i_write_addr >> BANK_W);
    assign w_rd_bank = BANK_IW'(i_read_addr % NUM_BANKS);
    assign w_rd_row  = ROW_IW'(i_read_addr >> BANK_W);

    // ------------------------------------------------------------------
    // Bank memories: byte-write, registered read (read-before-write)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_bank_rd [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [ROWS];
        logic [DATA_WIDTH-1:0] r_rd_word;

        always_ff @(posedge i_clk) begin
            if (w_clr_en) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_wr_en && (w_wr_bank == BANK_IW'(b))) begin
                for (int k = 0; k < NUM_BYTES; k++) begin
                    if (i_wstrb[k]) begin
                        r_mem[w_wr_row][8*k +: 8] <= i_data[8*k +: 8];
                    end
                end
            end
            if (w_rd_en && (w_rd_bank == BANK_IW'(b))) begin
                r_rd_word <= r_mem[w_rd_row];
            end
        end

        assign w_bank_rd[b] = r_rd_word;
    end

    // ------------------------------------------------------------------
    // Read stage 1: bank select plus write-first bypass.
    // The bank itself always returns the old word; with WRITE_FIRST the
    // strobed bytes of a same-address write are overlaid afterwards so the
    // memory stays a plain block-RAM template.
    // ------------------------------------------------------------------
    logic                  r_v1;
    logic [BANK_IW-1:0]    r_rd_bank;
    logic                  r_byp_hit;
    logic [NUM_BYTES-1:0]  r_byp_strb;
    logic [DATA_WIDTH-1:0] r_byp_data;
    logic [DATA_WIDTH-1:0] w_s1_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1       <= 1'b0;
            r_rd_bank  <= '0;
            r_byp_hit  <= 1'b0;
            r_byp_strb <= '0;
            r_byp_data <= '0;
        end else begin
            r_v1      <= w_rd_en;
            r_byp_hit <= (WRITE_FIRST != 0) && w_rd_en && w_wr_en
                         && (i_read_addr == i_write_addr);
            if (w_rd_en) begin
                r_rd_bank  <= w_rd_bank;
                r_byp_strb <= i_wstrb;
                r_byp_data <= i_data;
            end
        end
    end

    always_comb begin
        w_s1_data = w_bank_rd[r_rd_bank];
        if (r_byp_hit) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (r_byp_strb[k]) begin
                    w_s1_data[8*k +: 8] = r_byp_data[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage (optional second register)
    // ------------------------------------------------------------------
    if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_v2;
        logic [DATA_WIDTH-1:0] r_d2;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_v2 <= 1'b0;
                r_d2 <= '0;
            end else begin
                r_v2 <= r_v1;
                r_d2 <= r_v1 ? w_s1_data : '0;
            end
        end

        assign o_valid = r_v2;
        assign o_data  = r_d2;
    end else begin : g_lat1
        assign o_valid = r_v1;
        assign o_data  = r_v1 ? w_s1_data : '0;
    end

endmodule

// File: doc/banked_ram_array.md
Name: banked_ram_array

Overview:
- Parametrised successor to the single-bank simple-dual-port scratch RAM used by the convolution datapath.
- Adds byte-enable writes, registered read with configurable latency and a valid strobe, and a selectable read-during-write policy.
- Adds a hardware clear sequencer that zeroes all banks in parallel, replacing initial-block zeroing.
- Sits between the convolution engine and its line/weight buffers; one write port and one read port per cycle.

Parameters:
- VALID_ADDR_WIDTH, 14: word address width; depth DEPTH = 2**VALID_ADDR_WIDTH.
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- NUM_BANKS, 4: power of two, at most DEPTH. Bank = addr[log2(NUM_BANKS)-1:0]; row = remaining upper bits.
- READ_LATENCY, 1: 1 or 2 cycles from read request to o_valid.
- WRITE_FIRST, 1: 1 = same-cycle same-address read returns the newly written data; 0 = returns the old data.
- CLEAR_ON_RESET, 1: 1 = clear sequence starts automatically when reset releases.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_clear  in  1  pulse; starts a clear sequence when idle
- o_busy  out  1  high while clearing; ports are ignored
- i_we  in  1  write enable
- i_write_addr  in  VALID_ADDR_WIDTH  write word address
- i_wstrb  in  DATA_WIDTH/8  byte enables; bit k covers data[8k+7:8k]
- i_data  in  DATA_WIDTH  write data
- i_re  in  1  read request
- i_read_addr  in  VALID_ADDR_WIDTH  read word address
- o_data  out  DATA_WIDTH  read data; zero when o_valid is low
- o_valid  out  1  o_data valid this cycle

Behaviour:
- Reset: i_rst (synchronous, active-high) on i_clk.
  - o_valid=0, o_data=0, read pipeline flushed.
  - FSM to CLEAR with row counter 0 if CLEAR_ON_RESET=1, otherwise to IDLE.
  - o_busy is registered: 1 in the first cycle after reset if CLEAR_ON_RESET=1, else 0.
  - Memory contents are not altered by i_rst itself.
- FSM states:
  - IDLE: o_busy=0. i_clear=1 -> CLEAR with counter 0.
  - CLEAR: o_busy=1. Each cycle, writes zero to row[counter] of every bank at once, then increments the counter. At counter = DEPTH/NUM_BANKS-1, that row is written and the FSM returns to IDLE. A clear takes exactly DEPTH/NUM_BANKS cycles. i_clear while in CLEAR is ignored.
  - i_rst in any state, including mid-clear, restarts per the reset rule above.
- Writes (IDLE only): on a clock edge with i_we=1, each byte k with i_wstrb[k]=1 is updated. Bytes with a 0 strobe keep their value. i_wstrb=0 is a no-op.
- Reads (IDLE only):
  - i_re=1 at edge N gives o_valid=1 and o_data=word for exactly one cycle after edge N+READ_LATENCY-1. At READ_LATENCY=1 this is the cycle after the request.
  - One read is accepted per cycle, fully pipelined; back-to-back reads give back-to-back valids.
- Busy gating: i_we and i_re are ignored while o_busy=1, and no o_valid results from them. Reads accepted before CLEAR entry complete normally with their pre-clear data.
- Read-during-write, same address and same edge:
  - WRITE_FIRST=1: returns the byte-merged new word (strobed bytes new, others old).
  - WRITE_FIRST=0: returns the old word.
  - Different addresses never interact.
- Address range: all VALID_ADDR_WIDTH-bit addresses are legal; no out-of-range case exists.
- Timing: bank memories use registered read (block-RAM inferable). Any second pipeline stage is on the output.

Test Plan:
- Reset clear (VALID_ADDR_WIDTH=6, NUM_BANKS=4, CLEAR_ON_RESET=1): preload nonzero, pulse i_rst -> o_busy high exactly 16 cycles. Then reads of addresses 0..63 all return 0 with o_valid, one per cycle.
- Byte strobes: write 0xAABBCCDD to address 5 with wstrb=1111, then 0x11223344 with wstrb=0101 -> read of address 5 returns 0xAA22CC44.
- Latency: READ_LATENCY=2, reads issued on 3 consecutive cycles to addresses 1,2,3 -> o_valid high on 3 consecutive cycles starting 2 cycles after the first request, data in order. o_data=0 whenever o_valid=0.
- Read-during-write at address 9 holding 0x0 while writing 0xDEADBEEF: WRITE_FIRST=1 -> returns 0xDEADBEEF; WRITE_FIRST=0 -> returns 0x00000000, and the next read returns 0xDEADBEEF.
- Busy gating / mid-clear reset: i_clear, then a write of 0x55 to address 3 during busy -> ignored, address 3 reads 0 after clear. i_rst asserted at clear cycle 7 -> busy restarts and lasts the full 16 cycles.
- CLEAR_ON_RESET=0: after reset o_busy=0 immediately and a read of a previously written address returns its old value. i_clear then zeroes the array in 16 cycles.
